// File: rtl/gate_apply_2x2.sv
// gate_apply_2x2: applies one 2x2 complex gate to an amplitude pair using a
// single complex multiplier shared over four cycles, with per-component
// saturation and valid/ready handshakes on both sides.

// complex_fix_mul: combinational complex product of two signed fixed-point
// numbers (W bits, W-1 fractional), rounded to nearest and clamped to PW bits.
module complex_fix_mul #(
    parameter int W  = 19,
    parameter int PW = 20
) (
    input  logic [0:1][W-1:0]  a,
    input  logic [0:1][W-1:0]  b,
    output logic [0:1][PW-1:0] p
);
    localparam int FW = 2 * W + 1;
    localparam int FB = W - 1;
    localparam logic signed [FW-1:0] RND  = FW'(1) << (FB - 1);
    localparam logic signed [FW-1:0] PMAX = FW'((1 << (PW - 1)) - 1);
    localparam logic signed [FW-1:0] PMIN = ~PMAX;

    function automatic logic signed [FW-1:0] sx(input logic [W-1:0] v);
        return {{(FW - W){v[W-1]}}, v};
    endfunction

    function automatic logic [PW-1:0] scale(input logic signed [FW-1:0] full);
        logic signed [FW-1:0] r;
        r = (full + RND) >>> FB;
        if (r > PMAX)      return PMAX[PW-1:0];
        else if (r < PMIN) return PMIN[PW-1:0];
        else               return r[PW-1:0];
    endfunction

    // Full-precision real/imag sums of products, then round and clamp
    always_comb begin
        p[0] = scale(sx(a[0]) * sx(b[0]) - sx(a[1]) * sx(b[1]));
        p[1] = scale(sx(a[0]) * sx(b[1]) + sx(a[1]) * sx(b[0]));
    end
endmodule

module gate_apply_2x2 #(
    parameter int W  = 19,
    parameter int PW = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:1][W-1:0] g00,
    input  logic [0:1][W-1:0] g01,
    input  logic [0:1][W-1:0] g10,
    input  logic [0:1][W-1:0] g11,
    input  logic [0:1][W-1:0] a0,
    input  logic [0:1][W-1:0] a1,
    output logic [0:1][W-1:0] out0,
    output logic [0:1][W-1:0] out1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             saturated
);
    localparam int AW = PW + 1;
    localparam logic signed [AW-1:0] SMAX = AW'((1 << (W - 1)) - 1);
    localparam logic signed [AW-1:0] SMIN = ~SMAX;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;
    logic [1:0] step;

    // Latched gate (index = step) and amplitudes (index = step[0])
    logic [0:1][W-1:0] g_r [0:3];
    logic [0:1][W-1:0] a_r [0:1];

    logic [0:1][W-1:0]  mul_g, mul_a;
    logic [0:1][PW-1:0] prod;
    logic [0:1][AW-1:0] prod_x, acc0, acc1, acc0_sum, acc1_fin;
    logic [0:1][W-1:0]  sat0, sat1;
    logic [0:1]         clip0, clip1;

    // Returns {clip, value}: value clamped to the W-bit signed range
    function automatic logic [W:0] sat(input logic signed [AW-1:0] v);
        if (v > SMAX)      return {1'b1, SMAX[W-1:0]};
        else if (v < SMIN) return {1'b1, SMIN[W-1:0]};
        else               return {1'b0, v[W-1:0]};
    endfunction

    assign in_ready = (state == IDLE);

    complex_fix_mul #(.W(W), .PW(PW)) u_mul (
        .a (mul_g),
        .b (mul_a),
        .p (prod)
    );

    // Operand mux, sign extension, accumulation sums and saturation
    always_comb begin
        mul_g = g_r[step];
        mul_a = a_r[step[0]];
        for (int c = 0; c < 2; c++) begin
            prod_x[c]   = {prod[c][PW-1], prod[c]};
            acc0_sum[c] = acc0[c] + prod_x[c];
            acc1_fin[c] = acc1[c] + prod_x[c];
            {clip0[c], sat0[c]} = sat(acc0[c]);
            {clip1[c], sat1[c]} = sat(acc1_fin[c]);
        end
    end

    // State register
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update together from pre-edge values; blocking here would create races.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic
    // NOTE: the default is assigned first so every path drives state_nx;
    // a missing branch would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)   state_nx = MUL;
            MUL:     if (step == 2'd3) state_nx = DONE;
            DONE:    if (out_ready)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture on accept
    // NOTE: these registers are deliberately not reset: they are only read in
    // MUL, which is reachable solely through an accept that loads them.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            g_r[0] <= g00;
            g_r[1] <= g01;
            g_r[2] <= g10;
            g_r[3] <= g11;
            a_r[0] <= a0;
            a_r[1] <= a1;
        end
    end

    // Step counter, accumulators, result registers and output handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            step      <= 2'd0;
            acc0      <= '0;
            acc1      <= '0;
            out0      <= '0;
            out1      <= '0;
            saturated <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: step <= 2'd0;
                MUL: begin
                    step <= step + 2'd1;
                    case (step)
                        2'd0: acc0 <= prod_x;
                        2'd1: acc0 <= acc0_sum;
                        2'd2: acc1 <= prod_x;
                        default: begin
                            out0      <= sat0;
                            out1      <= sat1;
                            saturated <= |{clip0, clip1};
                            out_valid <= 1'b1;
                        end
                    endcase
                end
                DONE: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule
